// File: rtl/cfg_ser_pkg.sv
// Shared types and helpers for the configuration serializer.
// Build option: CFG_SER_PARITY_EN appends an even-parity bit to every word.
package cfg_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } cfg_state_t;

`ifdef CFG_SER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Serial bits emitted per configuration word (data bits plus optional parity).
    function automatic int cfg_nbits(input int word);
        return word + (PARITY_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in serial-out word register with bit counter; sdi is registered.
// Build option: CFG_SER_PARITY_EN shifts an even-parity bit after the data bits.
module cfg_piso
    import cfg_ser_pkg::*;
#(
    parameter int WORD  = 8,
    parameter int NBITS = cfg_nbits(WORD),
    parameter int CNTW  = $clog2(NBITS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] data,
    input  logic            capture,
    input  logic            advance,
    output logic            sdi,
    output logic            last
);

    logic [WORD-1:0] shreg;
    logic [CNTW-1:0] bit_cnt;
    logic            sdi_q;
    logic            next_bit;

`ifdef CFG_SER_PARITY_EN
    logic par_q;

    // Once the final data bit is on sdi, the parity bit follows.
    assign next_bit = (bit_cnt == CNTW'(WORD - 1)) ? par_q : shreg[WORD-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (capture) begin
            par_q <= ^data;
        end
    end
`else
    assign next_bit = shreg[WORD-1];
`endif

    // bit_cnt names the bit currently driven on sdi.
    assign last = (bit_cnt == CNTW'(NBITS - 1));
    assign sdi  = sdi_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sdi_q   <= 1'b0;
        end else if (capture) begin
            shreg   <= {data[WORD-2:0], 1'b0};
            sdi_q   <= data[WORD-1];
            bit_cnt <= '0;
        end else if (advance) begin
            shreg   <= {shreg[WORD-2:0], 1'b0};
            sdi_q   <= next_bit;
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
            sdi_q   <= 1'b0;
            bit_cnt <= '0;
        end
    end

endmodule

// File: rtl/cfg_serializer.sv
// Configuration loader: accepts words over valid/ready, shifts them MSB-first, strobes load per frame.
// Build option: CFG_SER_PARITY_EN (parity bit per word, handled inside cfg_piso).
module cfg_serializer
    import cfg_ser_pkg::*;
#(
    parameter int WORD        = 8,
    parameter int FRAME_WORDS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic            sdi,
    output logic            shift_en,
    output logic            load,
    output logic            busy,
    output cfg_state_t      fsm_state
);

    localparam int NBITS = cfg_nbits(WORD);
    localparam int CW    = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_WORDS - 1);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and in_data must hold until transfer.

    cfg_state_t      state, state_next;
    logic [CW-1:0]   word_cnt, word_cnt_next;
    logic            shift_en_q, load_q;
    logic            last_bit;
    logic            ready_c;
    logic            hs;
    logic            advance;

    cfg_piso #(
        .WORD  (WORD),
        .NBITS (NBITS)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .data    (in_data),
        .capture (hs),
        .advance (advance),
        .sdi     (sdi),
        .last    (last_bit)
    );

    always_comb begin
        ready_c       = 1'b0;
        hs            = 1'b0;
        advance       = 1'b0;
        state_next    = state;
        word_cnt_next = word_cnt;

        case (state)
            IDLE:    ready_c = 1'b1;
            SHIFT:   ready_c = last_bit && (word_cnt != LAST_WORD);
            default: ready_c = 1'b0;
        endcase
        if (!reset || flush) begin
            ready_c = 1'b0;
        end
        hs = in_valid && ready_c;

        case (state)
            IDLE: begin
                if (hs) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    word_cnt_next = word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        state_next = LOAD;
                    end else if (hs) begin
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            LOAD: begin
                word_cnt_next = '0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Flush aborts the frame outright; no load follows.
        if (flush) begin
            state_next    = IDLE;
            word_cnt_next = '0;
            advance       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            shift_en_q <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state      <= state_next;
            word_cnt   <= word_cnt_next;
            shift_en_q <= (state_next == SHIFT);
            load_q     <= (state_next == LOAD);
        end
    end

    assign in_ready  = ready_c;
    assign shift_en  = shift_en_q;
    assign load      = load_q;
    assign busy      = (word_cnt != '0) || (state != IDLE);
    assign fsm_state = state;

endmodule
